vector_exec_unit: RTL and testbench



---
 rtl/vector_exec_unit_if.sv | 31 +++
 rtl/vector_exec_unit.sv | 148 ++++++++++++++
 tb/tb_vector_exec_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vector_exec_unit_if.sv
// Vector execution unit bus: start handshake, latched operands in, write-back
// result out. The execution unit takes the slave modport; the requester (or
// testbench) takes the master modport.
//   start/op/vd_in/va_flat/vb_flat/scalar : request and source operands
//   busy/we/vd_out/wd_flat/vz             : status and write-back to the VRF
interface vector_exec_unit_if #(
    parameter int unsigned NELEM = 5,
    parameter int unsigned WIDTH = 32
);
    logic                   start;
    logic [2:0]             op;
    logic [3:0]             vd_in;
    logic [NELEM*WIDTH-1:0] va_flat;
    logic [NELEM*WIDTH-1:0] vb_flat;
    logic [WIDTH-1:0]       scalar;
    logic                   busy;
    logic                   we;
    logic [3:0]             vd_out;
    logic [NELEM*WIDTH-1:0] wd_flat;
    logic                   vz;

    modport master (
        output start, op, vd_in, va_flat, vb_flat, scalar,
        input  busy, we, vd_out, wd_flat, vz
    );

    modport slave (
        input  start, op, vd_in, va_flat, vb_flat, scalar,
        output busy, we, vd_out, wd_flat, vz
    );
endinterface

// File: rtl/vector_exec_unit.sv
// Multi-cycle vector execution stage. Latches two NELEM-element source vectors
// on an accepted start, runs one element per cycle through a shared
// add/sub/mul/logic datapath, then pulses we for one cycle with the result.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : vector_exec_unit_if slave (request/operands in, write-back out)
module vector_exec_unit #(
    parameter int unsigned NELEM = 5,
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    vector_exec_unit_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NELEM);

    typedef logic [NELEM-1:0][WIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWb
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [2:0]        op_q, op_d;
    logic [3:0]        vd_q, vd_d;
    vec_t              va_q, va_d;
    vec_t              vb_q, vb_d;
    logic [WIDTH-1:0]  sc_q, sc_d;
    vec_t              res_q, res_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    // Output copies hold the last write-back values until the next one.
    vec_t              wd_q, wd_d;
    logic [3:0]        vd_out_q, vd_out_d;
    logic              vz_q, vz_d;

    logic [WIDTH-1:0]  a_el, b_el, acc_sum, el;
    logic [IdxW-1:0]   slot;
    logic              accept;

    // Shared element datapath.
    always_comb begin
        a_el    = va_q[idx_q];
        b_el    = vb_q[idx_q];
        acc_sum = acc_q + a_el;
        el      = '0;
        unique case (op_q)
            3'b000: el = a_el + b_el;
            3'b001: el = a_el - b_el;
            3'b010: el = a_el * b_el;
            3'b011: el = a_el & b_el;
            3'b100: el = a_el | b_el;
            3'b101: el = a_el ^ b_el;
            3'b110: el = acc_sum;
            3'b111: el = a_el + sc_q;
            default: el = '0;
        endcase
        // Reduce-sum keeps its running total in slot 0; slots 1..4 stay cleared.
        slot = (op_q == 3'b110) ? '0 : idx_q;
    end

    // The edge that ends WB is also an accept edge, giving back-to-back ops.
    assign accept = bus.start && (state_q == StIdle || state_q == StWb);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        vd_d     = vd_q;
        va_d     = va_q;
        vb_d     = vb_q;
        sc_d     = sc_q;
        res_d    = res_q;
        acc_d    = acc_q;
        wd_d     = wd_q;
        vd_out_d = vd_out_q;
        vz_d     = vz_q;

        case (state_q)
            StIdle: ;
            StExec: begin
                res_d[slot] = el;
                acc_d       = acc_sum;
                idx_d       = idx_q + 1'b1;
                if (idx_q == IdxW'(NELEM - 1)) begin
                    state_d  = StWb;
                    wd_d     = res_d;
                    vd_out_d = vd_q;
                    vz_d     = ~|res_d;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d = StExec;
            op_d    = bus.op;
            vd_d    = bus.vd_in;
            va_d    = bus.va_flat;
            vb_d    = bus.vb_flat;
            sc_d    = bus.scalar;
            res_d   = '0;
            acc_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            op_q     <= '0;
            vd_q     <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            sc_q     <= '0;
            res_q    <= '0;
            acc_q    <= '0;
            wd_q     <= '0;
            vd_out_q <= '0;
            vz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            vd_q     <= vd_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            sc_q     <= sc_d;
            res_q    <= res_d;
            acc_q    <= acc_d;
            wd_q     <= wd_d;
            vd_out_q <= vd_out_d;
            vz_q     <= vz_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.we      = (state_q == StWb);
    assign bus.vd_out  = vd_out_q;
    assign bus.wd_flat = wd_q;
    assign bus.vz      = vz_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
module tb_vector_exec_unit;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [3:0]   vd;
        logic [159:0] a;
        logic [159:0] b;
        logic [31:0]  s;
        logic [159:0] wd;
        logic         vz;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t tbl [9];

    vector_exec_unit_if #(.NELEM(5), .WIDTH(32)) bus ();

    vector_exec_unit #(.NELEM(5), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [159:0] v5(input logic [31:0] e0, input logic [31:0] e1,
                                       input logic [31:0] e2, input logic [31:0] e3,
                                       input logic [31:0] e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.op      = v.op;
        bus.vd_in   = v.vd;
        bus.va_flat = v.a;
        bus.vb_flat = v.b;
        bus.scalar  = v.s;
    endtask

    // Presents v with start, returns 1 time unit after the accept edge.
    task automatic start_op(input vec_t v, input bit keep);
        @(negedge clk);
        drive(v);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) begin
            bus.start   = 1'b0;
            bus.va_flat = ~v.a;
            bus.vb_flat = {5{32'hA5A5_5A5A}};
            bus.scalar  = 32'h1234_5678;
            bus.op      = ~v.op;
            bus.vd_in   = ~v.vd;
        end
    endtask

    // Called right after the accept edge T; checks we exactly at T+5.
    task automatic expect_result(input vec_t v, input logic busy_after);
        bit early   = 1'b0;
        bit notbusy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.we) early = 1'b1;
            if (!bus.busy) notbusy = 1'b1;
        end
        chk({v.name, ".we_early"}, early, 1'b0);
        chk({v.name, ".busy_exec"}, notbusy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, ".we"}, bus.we, 1'b1);
        chk({v.name, ".busy_wb"}, bus.busy, 1'b1);
        chk({v.name, ".vd_out"}, bus.vd_out, v.vd);
        chk({v.name, ".wd"}, bus.wd_flat, v.wd);
        chk({v.name, ".vz"}, bus.vz, v.vz);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, ".we_after"}, bus.we, 1'b0);
        chk({v.name, ".busy_after"}, bus.busy, busy_after);
        chk({v.name, ".wd_hold"}, bus.wd_flat, v.wd);
    endtask

    task automatic watch_no_we(input string name, input int cycles);
        bit seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.we) seen = 1'b1;
        end
        chk(name, seen, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl[0] = '{"vadd", 3'b000, 4'd7, v5(1, 2, 3, 32'hFFFF_FFFF, 10), v5(10, 20, 30, 1, 0),
                   32'd0, v5(11, 22, 33, 0, 10), 1'b0};
        tbl[1] = '{"vmul", 3'b010, 4'd3, v5(32'h10000, 3, 0, 5, 7), v5(32'h10000, 4, 9, 5, 7),
                   32'd0, v5(0, 12, 0, 25, 49), 1'b0};
        tbl[2] = '{"vsub", 3'b001, 4'd4, v5(32'h10000, 3, 0, 5, 7), v5(32'h10000, 4, 9, 5, 7),
                   32'd0, v5(0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 0, 0), 1'b0};
        tbl[3] = '{"vred", 3'b110, 4'd15, v5(1, 2, 3, 4, 5), v5(9, 9, 9, 9, 9),
                   32'd77, v5(15, 0, 0, 0, 0), 1'b0};
        tbl[4] = '{"vand0", 3'b011, 4'd1, v5(0, 0, 0, 0, 0), {5{32'hFFFF_FFFF}},
                   32'd0, v5(0, 0, 0, 0, 0), 1'b1};
        tbl[5] = '{"vor", 3'b100, 4'd2, v5(1, 2, 4, 8, 32'h8000_0000), v5(2, 2, 1, 0, 1),
                   32'd0, v5(3, 2, 5, 8, 32'h8000_0001), 1'b0};
        tbl[6] = '{"vxor", 3'b101, 4'd9, v5(32'hFF, 32'h0F, 5, 0, 32'hFFFF_FFFF),
                   v5(32'h0F, 32'h0F, 3, 0, 1), 32'd0, v5(32'hF0, 0, 6, 0, 32'hFFFF_FFFE), 1'b0};
        tbl[7] = '{"vscal", 3'b111, 4'd12, v5(1, 2, 3, 32'hFFFF_FFFF, 0), v5(100, 100, 100, 100, 100),
                   32'd5, v5(6, 7, 8, 4, 5), 1'b0};
        tbl[8] = '{"vredwrap", 3'b110, 4'd0, v5(32'hFFFF_FFFF, 1, 0, 0, 0), v5(1, 1, 1, 1, 1),
                   32'd0, v5(0, 0, 0, 0, 0), 1'b1};

        bus.start   = 1'b0;
        bus.op      = '0;
        bus.vd_in   = '0;
        bus.va_flat = '0;
        bus.vb_flat = '0;
        bus.scalar  = '0;
        reset       = 1'b0;

        // Reset asserted mid-clock takes effect immediately.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.we", bus.we, 1'b0);
        chk("rst.wd", bus.wd_flat, 160'd0);
        chk("rst.vd_out", bus.vd_out, 4'd0);
        chk("rst.vz", bus.vz, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        watch_no_we("idle.no_we", 10);

        for (int i = 0; i < 9; i++) begin
            start_op(tbl[i], 1'b0);
            expect_result(tbl[i], 1'b0);
        end

        // start pulsed at T+2 while busy is ignored and not queued.
        start_op(tbl[0], 1'b0);
        fork
            expect_result(tbl[0], 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                drive(tbl[1]);
                bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
        join
        watch_no_we("busy.not_queued", 8);

        // start held high through WB: second accept at T+6, its we at T+11.
        start_op(tbl[2], 1'b1);
        drive(tbl[3]);
        expect_result(tbl[2], 1'b1);
        bus.start = 1'b0;
        expect_result(tbl[3], 1'b0);

        // Reset at T+3 discards the operation.
        start_op(tbl[0], 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst.busy", bus.busy, 1'b0);
        chk("midrst.we", bus.we, 1'b0);
        chk("midrst.wd", bus.wd_flat, 160'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_no_we("midrst.no_we", 10);
        start_op(tbl[5], 1'b0);
        expect_result(tbl[5], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
